// File: rtl/serial_addsub_ctrl_if.sv
// Request/response bundle for the bit-serial add/subtract sequencer.
// The master issues operands; the slave reports busy/done and the result.
interface serial_addsub_ctrl_if #(
    parameter int N = 8
);
    logic         start;
    logic         op_a_ns;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         cout_final;

    modport master (
        output start, op_a_ns, op_a, op_b,
        input  busy, done, result, cout_final
    );

    modport slave (
        input  start, op_a_ns, op_a, op_b,
        output busy, done, result, cout_final
    );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer driving one external full adder/subtractor
// cell LSB first, holding each bit on the cell for SETTLE cycles.
module serial_addsub_ctrl #(
    parameter int N      = 8,
    parameter int SETTLE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_addsub_ctrl_if.slave  bus,
    output logic                 fa_a,
    output logic                 fa_b,
    output logic                 fa_cin,
    output logic                 fa_a_ns,
    input  logic                 fa_s,
    input  logic                 fa_cout
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [N-1:0]   r_result;
    logic [IW-1:0]  r_idx;
    logic [CW-1:0]  r_cnt;
    logic           r_cout_final;
    logic           r_busy;
    logic           r_done;
    logic           r_fa_a;
    logic           r_fa_b;
    logic           r_fa_cin;
    logic           r_fa_ns;

    logic           w_accept;
    logic           w_bit_end;
    logic           w_last;
    logic [N-1:0]   w_a_sh;
    logic [N-1:0]   w_b_sh;

    assign w_accept  = (r_state == S_IDLE) && bus.start;
    assign w_bit_end = (r_state == S_RUN) && (r_cnt == CW'(SETTLE - 1));
    assign w_last    = (r_idx == IW'(N - 1));
    assign w_a_sh    = r_a >> 1;
    assign w_b_sh    = r_b >> 1;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.start) w_next = S_RUN;
            S_RUN:   if (w_bit_end && w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // r_fa_cin doubles as the carry/borrow flop between bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_result     <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_cout_final <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fa_a       <= 1'b0;
            r_fa_b       <= 1'b0;
            r_fa_cin     <= 1'b0;
            r_fa_ns      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a          <= bus.op_a;
                r_b          <= bus.op_b;
                r_result     <= '0;
                r_cout_final <= 1'b0;
                r_idx        <= '0;
                r_cnt        <= '0;
                r_busy       <= 1'b1;
                r_fa_a       <= bus.op_a[0];
                r_fa_b       <= bus.op_b[0];
                r_fa_cin     <= 1'b0;
                r_fa_ns      <= bus.op_a_ns;
            end else if (r_state == S_RUN) begin
                if (!w_bit_end) begin
                    r_cnt <= r_cnt + CW'(1);
                end else begin
                    r_result[r_idx] <= fa_s;
                    r_cnt           <= '0;
                    if (w_last) begin
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_cout_final <= fa_cout;
                        r_fa_a       <= 1'b0;
                        r_fa_b       <= 1'b0;
                        r_fa_cin     <= 1'b0;
                        r_fa_ns      <= 1'b0;
                    end else begin
                        r_idx    <= r_idx + IW'(1);
                        r_a      <= w_a_sh;
                        r_b      <= w_b_sh;
                        r_fa_a   <= w_a_sh[0];
                        r_fa_b   <= w_b_sh[0];
                        r_fa_cin <= fa_cout;
                    end
                end
            end
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.result     = r_result;
    assign bus.cout_final = r_cout_final;
    assign fa_a           = r_fa_a;
    assign fa_b           = r_fa_b;
    assign fa_cin         = r_fa_cin;
    assign fa_a_ns        = r_fa_ns;
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench: N=4/SETTLE=2 directed cases and N=8/SETTLE=1 random ops,
// each sequencer driving a behavioural full adder/subtractor cell.
module tb_serial_addsub_ctrl;
    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_fail;
    int   b4;
    int   b8;
    int   done8;

    typedef struct {
        logic [7:0] res;
        logic       c;
        int         t;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];

    serial_addsub_ctrl_if #(.N(4)) b4i ();
    serial_addsub_ctrl_if #(.N(8)) b8i ();

    logic c4_a, c4_b, c4_ci, c4_ns, c4_s, c4_co;
    logic c8_a, c8_b, c8_ci, c8_ns, c8_s, c8_co;

    // behavioural bit cell: a+b+cin or a-b-bin
    assign c4_s  = c4_a ^ c4_b ^ c4_ci;
    assign c4_co = c4_ns
        ? ((c4_a & c4_b) | (c4_a & c4_ci) | (c4_b & c4_ci))
        : ((~c4_a & c4_b) | (~c4_a & c4_ci) | (c4_b & c4_ci));
    assign c8_s  = c8_a ^ c8_b ^ c8_ci;
    assign c8_co = c8_ns
        ? ((c8_a & c8_b) | (c8_a & c8_ci) | (c8_b & c8_ci))
        : ((~c8_a & c8_b) | (~c8_a & c8_ci) | (c8_b & c8_ci));

    serial_addsub_ctrl #(.N(4), .SETTLE(2)) u4 (
        .clk     (clk),
        .rst     (rst),
        .bus     (b4i),
        .fa_a    (c4_a),
        .fa_b    (c4_b),
        .fa_cin  (c4_ci),
        .fa_a_ns (c4_ns),
        .fa_s    (c4_s),
        .fa_cout (c4_co)
    );

    serial_addsub_ctrl #(.N(8), .SETTLE(1)) u8 (
        .clk     (clk),
        .rst     (rst),
        .bus     (b8i),
        .fa_a    (c8_a),
        .fa_b    (c8_b),
        .fa_cin  (c8_ci),
        .fa_a_ns (c8_ns),
        .fa_s    (c8_s),
        .fa_cout (c8_co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // reference: plain modulo-2^n arithmetic
    function automatic exp_t model(int n, logic [7:0] a, logic [7:0] b,
                                   logic add, int t);
        exp_t e;
        int   s;
        int   m;
        m = (1 << n) - 1;
        if (add) begin
            s = int'(a) + int'(b);
            e.c = s[n];
        end else begin
            s = int'(a) - int'(b);
            e.c = (a < b);
        end
        e.res = 8'(s & m);
        e.t   = t;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (b4i.busy) b4++;
        if (b4i.done) begin
            if (q4.size() == 0) begin
                chk("done4_unexpected", 1, 0);
            end else begin
                e = q4.pop_front();
                chk("result4", {28'd0, b4i.result}, {24'd0, e.res});
                chk("cout4", {31'd0, b4i.cout_final}, {31'd0, e.c});
                chk("latency4", cyc - e.t, 8);
                chk("busy_len4", b4, 8);
            end
            b4 = 0;
        end
        if (b8i.busy) b8++;
        if (b8i.done) begin
            done8++;
            if (q8.size() == 0) begin
                chk("done8_unexpected", 1, 0);
            end else begin
                e = q8.pop_front();
                chk("result8", {24'd0, b8i.result}, {24'd0, e.res});
                chk("cout8", {31'd0, b8i.cout_final}, {31'd0, e.c});
                chk("latency8", cyc - e.t, 8);
                chk("busy_len8", b8, 8);
            end
            b8 = 0;
        end
    end

    // while the DUT is busy or in DONE, start and operands are noise
    task automatic go4(input logic [3:0] a, input logic [3:0] b,
                       input logic add);
        int t;
        t = 0;
        @(negedge clk);
        while ((b4i.busy || b4i.done) && t < 200) begin
            b4i.start = 1'($urandom_range(0, 1));
            b4i.op_a  = 4'($urandom);
            b4i.op_b  = 4'($urandom);
            @(negedge clk);
            t++;
        end
        chk("idle_wait4", {31'd0, t < 200}, 1);
        b4i.start   = 1'b1;
        b4i.op_a    = a;
        b4i.op_b    = b;
        b4i.op_a_ns = add;
        @(posedge clk);
        #1;
        q4.push_back(model(4, {4'd0, a}, {4'd0, b}, add, cyc));
        b4i.start   = 1'b0;
        b4i.op_a    = 4'($urandom);
        b4i.op_b    = 4'($urandom);
        b4i.op_a_ns = 1'($urandom);
    endtask

    task automatic go8(input logic [7:0] a, input logic [7:0] b,
                       input logic add);
        int t;
        t = 0;
        @(negedge clk);
        while ((b8i.busy || b8i.done) && t < 200) begin
            b8i.start = 1'($urandom_range(0, 1));
            b8i.op_a  = 8'($urandom);
            b8i.op_b  = 8'($urandom);
            @(negedge clk);
            t++;
        end
        chk("idle_wait8", {31'd0, t < 200}, 1);
        b8i.start   = 1'b1;
        b8i.op_a    = a;
        b8i.op_b    = b;
        b8i.op_a_ns = add;
        @(posedge clk);
        #1;
        q8.push_back(model(8, a, b, add, cyc));
        b8i.start   = 1'b0;
        b8i.op_a    = 8'($urandom);
        b8i.op_b    = 8'($urandom);
        b8i.op_a_ns = 1'($urandom);
    endtask

    task automatic wait4();
        int t;
        t = 0;
        while (q4.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("drain4", q4.size(), 0);
    endtask

    task automatic wait8();
        int t;
        t = 0;
        while (q8.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("drain8", q8.size(), 0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        b4     = 0;
        b8     = 0;
        done8  = 0;
        rst    = 1'b1;
        b4i.start = 1'b0; b4i.op_a = '0; b4i.op_b = '0; b4i.op_a_ns = 1'b0;
        b8i.start = 1'b0; b8i.op_a = '0; b8i.op_b = '0; b8i.op_a_ns = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset4", {24'd0, b4i.busy, b4i.done, b4i.cout_final,
                       c4_a, c4_b, c4_ci, c4_ns, 1'b0}, 0);
        chk("reset4_result", {28'd0, b4i.result}, 0);
        chk("reset8", {24'd0, b8i.busy, b8i.done, b8i.cout_final,
                       c8_a, c8_b, c8_ci, c8_ns, 1'b0}, 0);
        chk("reset8_result", {24'd0, b8i.result}, 0);
        @(negedge clk);
        rst = 1'b0;

        go4(4'h5, 4'h3, 1'b1);
        go4(4'hF, 4'h1, 1'b1);
        go4(4'h7, 4'h2, 1'b0);
        go4(4'h2, 4'h7, 1'b0);
        wait4();

        // start mid-run with other operands must be ignored
        go4(4'h9, 4'h4, 1'b1);
        @(negedge clk);
        @(negedge clk);
        b4i.start = 1'b1; b4i.op_a = 4'h1; b4i.op_b = 4'h1;
        @(negedge clk);
        b4i.start = 1'b0;
        go4(4'h3, 4'h3, 1'b0);
        wait4();

        // reset in the 4th RUN cycle abandons the op
        go4(4'h6, 4'h5, 1'b1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst4", {24'd0, b4i.busy, b4i.done, b4i.cout_final,
                        c4_a, c4_b, c4_ci, c4_ns, 1'b0}, 0);
        chk("midrst4_result", {28'd0, b4i.result}, 0);
        q4.delete();
        b4 = 0;
        b8 = 0;
        // reset wins over a simultaneous start
        @(negedge clk);
        b4i.start = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_vs_start", {31'd0, b4i.busy}, 0);
        @(negedge clk);
        b4i.start = 1'b0;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("no_done_after_rst", {31'd0, b4i.done}, 0);
        go4(4'hA, 4'h3, 1'b0);
        wait4();

        for (int i = 0; i < 20; i++)
            go4(4'($urandom), 4'($urandom), 1'($urandom));
        wait4();

        for (int i = 0; i < 200; i++)
            go8(8'($urandom), 8'($urandom), 1'($urandom));
        wait8();
        chk("done8_count", done8, 200);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
